// File: rtl/sa_job_sequencer.sv
// Run-control sequencer for the 4x4 systolic-array matmul subsystem: fetches one K per job,
// clears the array, streams K columns, waits out the pipeline drain, then commits 16 results.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for ap_start after reset
// FETCH  | instruction read strobe for job_idx
// DECODE | instruction word arrives; K==0 terminates the run
// CLEAR  | one-cycle clear of accumulators and A/B read counters
// STREAM | one A/B column read per cycle, K cycles
// DRAIN  | quiet cycles while the array skew flushes
// WRITE  | commit 16 results at base job_idx*16
// DONE   | ap_done held until the next ap_start
module sa_job_sequencer #(
   parameter int K_W          = 4,
   parameter int JOB_W        = 3,
   parameter int ARRAY_N      = 4,
   parameter int DRAIN_CYCLES = 7,
   parameter int OUT_W        = JOB_W + $clog2(ARRAY_N * ARRAY_N)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             ap_start_i,
   output logic             ap_done_o,
   output logic             busy_o,
   output logic             instr_rd_o,
   output logic [JOB_W-1:0] instr_addr_o,
   input  logic [K_W-1:0]   instr_data_i,
   output logic             sa_clr_o,
   output logic             rd_en_o,
   output logic             out_wr_o,
   output logic [OUT_W-1:0] out_base_o,
   output logic [JOB_W-1:0] job_idx_o
);

   localparam int DR_W  = $clog2(DRAIN_CYCLES + 1);
   localparam int CNT_W = (K_W > DR_W) ? K_W : DR_W;
   localparam logic [JOB_W-1:0] LAST_JOB = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_CLEAR,
      S_STREAM,
      S_DRAIN,
      S_WRITE,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [K_W-1:0]     k_q, k_d;
   logic [JOB_W-1:0]   job_idx_q, job_idx_d;

   logic               ap_done_q, ap_done_d;
   logic               busy_q, busy_d;
   logic               instr_rd_q, instr_rd_d;
   logic               sa_clr_q, sa_clr_d;
   logic               rd_en_q, rd_en_d;
   logic               out_wr_q, out_wr_d;
   logic [OUT_W-1:0]   out_base_q, out_base_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         k_q       <= '0;
         job_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         k_q       <= k_d;
         job_idx_q <= job_idx_d;
      end
   end

   // cnt is a down-counter shared by STREAM (K) and DRAIN; both exit on terminal count 1
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      k_d       = k_q;
      job_idx_d = job_idx_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (ap_start_i) begin
               state_d   = S_FETCH;
               job_idx_d = '0;
            end
         end
         S_FETCH: begin
            state_d = S_DECODE;
         end
         S_DECODE: begin
            if (instr_data_i == '0) begin
               state_d = S_DONE;
            end else begin
               k_d     = instr_data_i;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            cnt_d   = CNT_W'(k_q);
            state_d = S_STREAM;
         end
         S_STREAM: begin
            if (cnt_q == CNT_ONE) begin
               cnt_d   = CNT_W'(DRAIN_CYCLES);
               state_d = S_DRAIN;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_DRAIN: begin
            if (cnt_q == CNT_ONE) begin
               state_d = S_WRITE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_WRITE: begin
            if (job_idx_q == LAST_JOB) begin
               state_d = S_DONE;
            end else begin
               job_idx_d = job_idx_q + JOB_W'(1);
               state_d   = S_FETCH;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs decode the next state so every strobe leaves a flop aligned with its state
   always_comb begin
      busy_d     = !(state_d inside {S_IDLE, S_DONE});
      ap_done_d  = (state_d == S_DONE);
      instr_rd_d = (state_d == S_FETCH);
      sa_clr_d   = (state_d == S_CLEAR);
      rd_en_d    = (state_d == S_STREAM);
      out_wr_d   = (state_d == S_WRITE);
      out_base_d = '0;
      if (state_d == S_WRITE) begin
         out_base_d = OUT_W'(job_idx_d) * OUT_W'(ARRAY_N * ARRAY_N);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ap_done_q  <= 1'b0;
         busy_q     <= 1'b0;
         instr_rd_q <= 1'b0;
         sa_clr_q   <= 1'b0;
         rd_en_q    <= 1'b0;
         out_wr_q   <= 1'b0;
         out_base_q <= '0;
      end else begin
         ap_done_q  <= ap_done_d;
         busy_q     <= busy_d;
         instr_rd_q <= instr_rd_d;
         sa_clr_q   <= sa_clr_d;
         rd_en_q    <= rd_en_d;
         out_wr_q   <= out_wr_d;
         out_base_q <= out_base_d;
      end
   end

   assign ap_done_o    = ap_done_q;
   assign busy_o       = busy_q;
   assign instr_rd_o   = instr_rd_q;
   assign instr_addr_o = job_idx_q;
   assign sa_clr_o     = sa_clr_q;
   assign rd_en_o      = rd_en_q;
   assign out_wr_o     = out_wr_q;
   assign out_base_o   = out_base_q;
   assign job_idx_o    = job_idx_q;

endmodule

// File: tb/tb_sa_job_sequencer.sv
// Bench for sa_job_sequencer: instruction-memory vectors with scoreboarded result commits,
// plus hand-written reset, ignored-start and restart sequences.
module tb_sa_job_sequencer;

   localparam int DRAIN = 7;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ap_start = 1'b0;
   logic       ap_done, busy, instr_rd, sa_clr, rd_en, out_wr;
   logic [2:0] instr_addr, job_idx;
   logic [3:0] instr_data = 4'd0;
   logic [6:0] out_base;

   logic [3:0] imem [8];

   sa_job_sequencer dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .ap_start_i   (ap_start),
      .ap_done_o    (ap_done),
      .busy_o       (busy),
      .instr_rd_o   (instr_rd),
      .instr_addr_o (instr_addr),
      .instr_data_i (instr_data),
      .sa_clr_o     (sa_clr),
      .rd_en_o      (rd_en),
      .out_wr_o     (out_wr),
      .out_base_o   (out_base),
      .job_idx_o    (job_idx)
   );

   always #5 clk = ~clk;

   // synchronous-read instruction memory: data valid the cycle after instr_rd
   always @(posedge clk) if (instr_rd) instr_data <= imem[instr_addr];

   typedef struct {
      logic [31:0] imem_w;   // nibble j = imem[j]
      int          n_jobs;
      int          n_fetch;
      int          cycles;   // edges after the start edge until ap_done is seen
   } vec_t;

   typedef struct {
      int base;
      int k;
   } exp_t;

   vec_t vecs [6];
   exp_t exp_q [$];

   int checks = 0;
   int errors = 0;
   int fetch_total = 0, clr_total = 0, wr_total = 0, fetch_base = 0;
   int run_len = 0, since_rd = 100;
   logic prev_rd = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ap_done"}, ap_done, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_instr_rd"}, instr_rd, 0);
      chk({tag, "_instr_addr"}, instr_addr, 0);
      chk({tag, "_sa_clr"}, sa_clr, 0);
      chk({tag, "_rd_en"}, rd_en, 0);
      chk({tag, "_out_wr"}, out_wr, 0);
      chk({tag, "_out_base"}, out_base, 0);
      chk({tag, "_job_idx"}, job_idx, 0);
   endtask

   // Monitor/scoreboard: run lengths, drain gap and base are checked on each out_wr
   always @(negedge clk) begin
      if (rd_en) begin
         run_len  = prev_rd ? run_len + 1 : 1;
         since_rd = 0;
      end else begin
         since_rd++;
      end
      prev_rd = rd_en;
      chk("strobe_exclusive", int'(sa_clr) + int'(instr_rd) + int'(out_wr) > 1, 0);
      if (instr_rd) begin
         chk("instr_addr", instr_addr, fetch_total - fetch_base);
         fetch_total++;
      end
      if (sa_clr) clr_total++;
      if (out_wr) begin
         exp_t e;
         wr_total++;
         if (exp_q.size() == 0) begin
            chk("unexpected_out_wr", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("out_base", out_base, e.base);
            chk("rd_en_run_len", run_len, e.k);
            chk("drain_gap", since_rd, DRAIN + 1);
         end
      end
   end

   task automatic run_vec(input int vi, input int pulse_at);
      int n, f0, c0, w0, exp_job;
      bit done;
      for (int j = 0; j < 8; j++) imem[j] = vecs[vi].imem_w[4*j +: 4];
      exp_q.delete();
      for (int j = 0; j < 8; j++) begin
         if (imem[j] == 4'd0) break;
         exp_q.push_back('{base: j * 16, k: int'(imem[j])});
      end
      fetch_base = fetch_total;
      f0 = fetch_total; c0 = clr_total; w0 = wr_total;
      @(negedge clk) ap_start = 1'b1;
      @(posedge clk);
      @(negedge clk) ap_start = 1'b0;
      chk("start_ap_done_clear", ap_done, 0);
      chk("start_busy", busy, 1);
      chk("start_instr_rd", instr_rd, 1);
      chk("start_job_idx", job_idx, 0);
      n = 0; done = 0;
      while (!done && n < 400) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         ap_start = (n == pulse_at);
         if (ap_done) done = 1;
      end
      ap_start = 1'b0;
      chk("done_reached", int'(done), 1);
      chk("done_latency", n, vecs[vi].cycles);
      chk("busy_in_done", busy, 0);
      exp_job = (vecs[vi].n_jobs == 8) ? 7 : vecs[vi].n_jobs;
      chk("job_idx_in_done", job_idx, exp_job);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("ap_done_held", ap_done, 1);
      chk("fetch_count", fetch_total - f0, vecs[vi].n_fetch);
      chk("clr_count", clr_total - c0, vecs[vi].n_jobs);
      chk("wr_count", wr_total - w0, vecs[vi].n_jobs);
      chk("scoreboard_empty", exp_q.size(), 0);
   endtask

   initial begin
      vecs[0] = '{32'h0000_0003, 1, 2, 16};   // {3,0}
      vecs[1] = '{32'h0000_0024, 2, 3, 30};   // {4,2,0}
      vecs[2] = '{32'h1111_1111, 8, 8, 96};   // all ones, 8 jobs
      vecs[3] = '{32'h0000_0000, 0, 1, 2};    // immediate K==0
      vecs[4] = '{32'h0000_000F, 1, 2, 28};   // max K
      vecs[5] = '{32'h8765_4321, 8, 8, 124};  // K = 1..8
      for (int j = 0; j < 8; j++) imem[j] = 4'd0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("por");
      rst = 1'b0;

      for (int v = 0; v < 6; v++) run_vec(v, -1);

      // ap_start pulsed during STREAM of job 0 must not disturb timing
      run_vec(1, 5);

      // Reset mid-job while in DRAIN: no partial commit, outputs cleared at once
      for (int j = 0; j < 8; j++) imem[j] = 4'd1;
      exp_q.delete();
      fetch_base = fetch_total;
      begin
         int w0;
         w0 = wr_total;
         @(negedge clk) ap_start = 1'b1;
         @(posedge clk);
         @(negedge clk) ap_start = 1'b0;
         repeat (7) @(posedge clk);
         @(negedge clk);
         chk("pre_rst_busy", busy, 1);
         chk("pre_rst_rd_en", rd_en, 0);
         rst = 1'b1;
         @(posedge clk);
         @(negedge clk);
         check_zero("rst1");
         @(posedge clk);
         @(negedge clk);
         check_zero("rst2");
         rst = 1'b0;
         repeat (12) @(posedge clk);
         @(negedge clk);
         chk("post_rst_busy", busy, 0);
         chk("post_rst_ap_done", ap_done, 0);
         chk("post_rst_no_write", wr_total - w0, 0);
      end

      // rst and ap_start together: reset wins
      rst = 1'b1;
      ap_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_wins_busy", busy, 0);
      chk("rst_wins_instr_rd", instr_rd, 0);
      rst = 1'b0;
      ap_start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("idle_after_rst_busy", busy, 0);

      run_vec(0, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
